div_rest_param: RTL and testbench



---
 rtl/div_pkg.sv | 29 ++
 rtl/div_rest_param_if.sv | 16 +
 rtl/div_rest_step.sv | 26 ++
 rtl/div_rest_param.sv | 149 ++++++++++++++
 tb/tb_div_rest_param.sv | 136 +++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types for the restoring divider: op encodings, FSM states and a
// conditional-negate helper used to form and restore operand magnitudes.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Widest operand the helper supports; callers truncate to their own width.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOOP = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Two's-complement negation when neg is set; low bits are width-independent.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
    if (neg) begin
      return ~v + 64'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/div_rest_param_if.sv
// Start/busy/done handshake and operand/result bus between the pipeline
// controller (master) and the divider (slave).
interface div_rest_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, input result, busy, done);
  modport slave  (input start, op, a, b, output result, busy, done);
endinterface

// File: rtl/div_rest_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it does not borrow.
module div_rest_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] diff_s;

  // Trial subtraction; the extra top bit acts as the borrow flag.
  always_comb begin
    diff_s = {rem_i, quot_i[WIDTH-1]} - {1'b0, divs_i};
    quot_o = {quot_i[WIDTH-2:0], ~diff_s[WIDTH]};
    if (diff_s[WIDTH]) begin
      rem_o = {rem_i[WIDTH-2:0], quot_i[WIDTH-1]};
    end else begin
      rem_o = diff_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_rest_param.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional build macro DIV_FAST_ZERO_EN: divide-by-zero skips the iteration loop.
module div_rest_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rstlow,
  div_rest_param_if.slave dif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             is_rem_q, is_rem_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] divs_q, divs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             signed_op_s;
  logic [WIDTH-1:0] step_rem_s, step_quot_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
    logic [MAX_W-1:0] t;
    t = cond_neg(MAX_W'(v), neg);
    return t[WIDTH-1:0];
  endfunction

  div_rest_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .divs_i (divs_q),
    .rem_o  (step_rem_s),
    .quot_o (step_quot_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    is_rem_d    = is_rem_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    bz_d        = bz_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    divs_d      = divs_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    signed_op_s = (dif.op == OP_DIV) | (dif.op == OP_REM);
    case (state_q)
      ST_IDLE: begin
        if (dif.start) begin
          is_rem_d = (dif.op == OP_REM) | (dif.op == OP_REMU);
          sa_d     = signed_op_s & dif.a[WIDTH-1];
          sb_d     = signed_op_s & dif.b[WIDTH-1];
          bz_d     = (dif.b == {WIDTH{1'b0}});
          quot_d   = neg_w(dif.a, sa_d);
          divs_d   = neg_w(dif.b, sb_d);
          rem_d    = {WIDTH{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
`ifdef DIV_FAST_ZERO_EN
          // Zero divisor: the loop would yield all-ones quotient and |a| remainder.
          if (bz_d) begin
            quot_d  = {WIDTH{1'b1}};
            rem_d   = neg_w(dif.a, sa_d);
            state_d = ST_FIX;
          end else begin
            state_d = ST_LOOP;
          end
`else
          state_d = ST_LOOP;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOP: begin
        rem_d  = step_rem_s;
        quot_d = step_quot_s;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_LOOP;
        end
      end
      ST_FIX: begin
        // Zero divisor keeps the all-ones quotient unsigned-looking for DIV too.
        if (is_rem_q) begin
          result_d = neg_w(rem_q, sa_q);
        end else begin
          result_d = neg_w(quot_q, (sa_q ^ sb_q) & ~bz_q);
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstlow) begin
    if (!rstlow) begin
      state_q  <= ST_IDLE;
      is_rem_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      quot_q   <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      divs_q   <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_rem_q <= is_rem_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      divs_q   <= divs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dif.result = result_q;
  assign dif.busy   = busy_q;
  assign dif.done   = done_q;

endmodule

// File: tb/tb_div_rest_param.sv
// Directed bench for div_rest_param at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_div_rest_param;
  import div_pkg::*;

`ifdef DIV_FAST_ZERO_EN
  localparam int LZ = 1;
`else
  localparam int LZ = 33;
`endif

  logic clk = 1'b0;
  logic rstlow;
  int   checks = 0;
  int   failures = 0;
  logic [63:0] q32[$];
  logic [63:0] q8[$];

  always #5 clk = ~clk;

  div_rest_param_if #(.WIDTH(32)) if32 ();
  div_rest_param_if #(.WIDTH(8))  if8 ();

  div_rest_param #(.WIDTH(32)) dut32 (.clk(clk), .rstlow(rstlow), .dif(if32.slave));
  div_rest_param #(.WIDTH(8))  dut8  (.clk(clk), .rstlow(rstlow), .dif(if8.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // hold: edges start stays high (2 = raised during a DONE cycle); poke: cycle to inject an ignored start.
  task automatic op32(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat_exp, input int hold, input bit tail, input int poke);
    int lat;
    logic [63:0] e;
    @(negedge clk);
    if32.start = 1'b1; if32.op = op; if32.a = a; if32.b = b;
    q32.push_back({32'd0, exp});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i < hold - 1) chk({tag, "_ignored_in_done"}, {63'd0, if32.busy}, 64'd0);
    end
    chk({tag, "_busy_after_start"}, {63'd0, if32.busy}, 64'd1);
    if32.start = 1'b0; if32.op = 2'($urandom); if32.a = $urandom; if32.b = $urandom;
    lat = 0;
    while (if32.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (poke != 0) begin
        if32.start = (lat == poke);
        if (lat == poke) begin if32.op = OP_DIVU; if32.a = 32'd9; if32.b = 32'd3; end
      end
    end
    e = q32.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_result"}, {32'd0, if32.result}, e);
    if (tail) begin
      @(posedge clk); #1;
      chk({tag, "_idle_after"}, {62'd0, if32.busy, if32.done}, 64'd0);
    end
  endtask

  task automatic op8(input string tag, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp);
    int lat;
    logic [63:0] e;
    @(negedge clk);
    if8.start = 1'b1; if8.op = op; if8.a = a; if8.b = b;
    q8.push_back({56'd0, exp});
    @(posedge clk); #1;
    if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
    lat = 0;
    while (if8.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    e = q8.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'd9);
    chk({tag, "_result"}, {56'd0, if8.result}, e);
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    rstlow = 1'b0;
    if32.start = 1'b0; if32.op = 2'b00; if32.a = 32'd0; if32.b = 32'd0;
    if8.start = 1'b0;  if8.op = 2'b00;  if8.a = 8'd0;   if8.b = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy32", {63'd0, if32.busy}, 64'd0);
    chk("rst_done32", {63'd0, if32.done}, 64'd0);
    chk("rst_result32", {32'd0, if32.result}, 64'd0);
    chk("rst_result8", {56'd0, if8.result}, 64'd0);
    rstlow = 1'b1;

    op32("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1, 1'b0, 0);
    op32("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 2, 1'b1, 0);
    op32("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1, 1'b1, 0);
    op32("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1, 1'b1, 0);
    op32("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1, 1'b1, 0);
    op32("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1, 1'b1, 0);
    op32("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1, 1'b1, 0);
    op32("div_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LZ, 1, 1'b1, 0);
    op32("rem_by0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LZ, 1, 1'b1, 0);
    op32("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LZ, 1, 1'b1, 0);
    op32("divu_poke", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1, 1'b1, 4);

    // Abort an operation with reset at cycle N+10.
    @(negedge clk);
    if32.start = 1'b1; if32.op = OP_DIVU; if32.a = 32'd100; if32.b = 32'd7;
    @(posedge clk); #1;
    if32.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rstlow = 1'b0;
    #1;
    chk("abort_busy", {63'd0, if32.busy}, 64'd0);
    chk("abort_done", {63'd0, if32.done}, 64'd0);
    chk("abort_result", {32'd0, if32.result}, 64'd0);
    @(negedge clk);
    rstlow = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (if32.done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);

    op8("w8_divu_200_9", OP_DIVU, 8'd200, 8'd9, 8'd22);
    op8("w8_div_ovf", OP_DIV, 8'h80, 8'hFF, 8'h80);
    op8("w8_rem_ovf", OP_REM, 8'h80, 8'hFF, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
